// File: rtl/pio_in_edge_capture.sv
// rtl/pio_in_edge_capture.sv - Avalon-MM input PIO with synchroniser, sticky edge capture and irq
module pio_in_edge_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_irq_mask;
  logic [WIDTH-1:0]                  r_edge_capture;

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_sync_data;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_ok;

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect & ~read_n;

  // Bits of writedata above WIDTH are ignored on every register.
  assign w_unused_ok = ^writedata;

  assign w_sync_data = r_sync[SYNC_STAGES-1];

  // Shift the external inputs through the synchroniser chain; stage 0 takes in_port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  // Delay sync_data by one cycle; resetting to 0 means a high input at release reads as a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_sync_data;
    end
  end

  assign w_rise = w_sync_data & ~r_prev;
  assign w_fall = ~w_sync_data & r_prev;
  assign w_edge = (EDGE_TYPE == 0) ? w_rise :
                  (EDGE_TYPE == 1) ? w_fall :
                                     (w_rise | w_fall);

  assign w_clr = (w_wr && (address == ADDR_CAPTURE)) ? writedata[WIDTH-1:0] : '0;

  // Interrupt mask register, written from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
    end else if (w_wr && (address == ADDR_MASK)) begin
      r_irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky capture: clear first, then OR in new edges so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_capture <= '0;
    end else begin
      r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
    end
  end

  // Select the addressed register, zero-extended; unmapped words read 0.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_sync_data;
      ADDR_MASK:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
      ADDR_CAPTURE: w_rd_mux[WIDTH-1:0] = r_edge_capture;
      default:      w_rd_mux = '0;
    endcase
  end

  // Register read data on a read strobe; it holds otherwise. Values are pre-write on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (w_rd) begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = (IRQ_TYPE == 1) ? |(r_edge_capture & r_irq_mask)
                               : |(w_sync_data & r_irq_mask);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb/tb_pio_in_edge_capture.sv - scoreboard bench for pio_in_edge_capture
module tb_pio_in_edge_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_a;
  logic [7:0]  in_b;

  logic [31:0] rd_main, rd_fall, rd_any, rd_lvl;
  logic        irq_main, irq_fall, irq_any, irq_lvl;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  pio_in_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_main (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_main), .in_port(in_a), .irq(irq_main));

  pio_in_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_fall), .in_port(in_b), .irq(irq_fall));

  pio_in_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_any), .in_port(in_b), .irq(irq_any));

  pio_in_edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_lvl), .in_port(in_b), .irq(irq_lvl));

  // Called at a negedge: strobe across the next posedge, compare main readdata at the following negedge.
  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    chipselect = 1'b1; read_n = 1'b0; address = a;
    sb_q.push_back('{exp: exp, name: name});
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    e = sb_q.pop_front();
    total++;
    if (rd_main !== e.exp) begin
      bad++;
      $display("FAIL %s: readdata=%h expected=%h", e.name, rd_main, e.exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic chk_bit(input logic obs, input logic exp, input string name);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 3'd0; writedata = 32'd0; in_a = 8'h00; in_b = 8'h00;
    #7;
    total++;
    if (rd_main !== 32'd0) begin
      bad++;
      $display("FAIL reset_readdata: got=%h expected=%h", rd_main, 32'd0);
    end
    chk_bit(irq_main, 1'b0, "reset_irq");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(3'd0, 32'h0, "reset_data");
    bus_read(3'd2, 32'h0, "reset_mask");
    bus_read(3'd3, 32'h0, "reset_capture");
    chk_bit(irq_main, 1'b0, "reset_irq_after");
  endtask

  task automatic test_sync_capture();
    in_a = 8'hA5;
    bus_read(3'd3, 32'h0,  "cap_before_k");
    bus_read(3'd0, 32'h0,  "data_at_k1_old");
    bus_read(3'd3, 32'h0,  "cap_at_k2_pre");
    bus_read(3'd3, 32'hA5, "cap_after_k2");
    bus_read(3'd0, 32'hA5, "data_synced");
  endtask

  task automatic test_mask_clear();
    sb_t e;
    chk_bit(irq_main, 1'b0, "irq_mask0");
    bus_write(3'd2, 32'hFFFF_FF01);
    chk_bit(irq_main, 1'b1, "irq_mask1");
    bus_read(3'd2, 32'h01, "mask_upper_ignored");
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, 32'hA4, "rw1c_bit0");
    chk_bit(irq_main, 1'b0, "irq_after_clear");
    bus_write(3'd3, 32'hFF);
    bus_read(3'd3, 32'h00, "rw1c_all");
    bus_write(3'd0, 32'hFF);
    bus_read(3'd0, 32'hA5, "data_ro");
    bus_write(3'd1, 32'hFF);
    bus_read(3'd1, 32'h0, "addr1_zero");
    bus_read(3'd6, 32'h0, "addr6_zero");
    // Read and write strobes together on the mask: read returns the pre-write value.
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = 3'd2; writedata = 32'h3C;
    sb_q.push_back('{exp: 32'h01, name: "collision_prewrite"});
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    e = sb_q.pop_front();
    total++;
    if (rd_main !== e.exp) begin
      bad++;
      $display("FAIL %s: readdata=%h expected=%h", e.name, rd_main, e.exp);
    end
    bus_read(3'd2, 32'h3C, "collision_write_applied");
  endtask

  task automatic test_set_wins();
    in_a = 8'hAD;
    repeat (2) @(negedge clk);
    bus_write(3'd3, 32'h08);
    bus_read(3'd3, 32'h08, "set_beats_clear");
  endtask

  task automatic test_edge_types();
    bus_write(3'd2, 32'h01);
    in_b = 8'h01;
    @(negedge clk);
    chk_bit(irq_lvl, 1'b0, "lvl_before_sync");
    @(negedge clk);
    chk_bit(irq_lvl, 1'b1, "lvl_after_sync");
    chk_bit(irq_any, 1'b0, "any_before_rise");
    @(negedge clk);
    chk_bit(irq_any, 1'b1, "any_after_rise");
    chk_bit(irq_fall, 1'b0, "fall_on_rise");
    in_b = 8'h00;
    @(negedge clk);
    chk_bit(irq_fall, 1'b0, "fall_high1");
    @(negedge clk);
    chk_bit(irq_fall, 1'b0, "fall_before_edge");
    chk_bit(irq_lvl, 1'b0, "lvl_low");
    @(negedge clk);
    chk_bit(irq_fall, 1'b1, "fall_after_edge");
  endtask

  task automatic test_async_reset();
    sb_t e;
    bus_write(3'd2, 32'hFF);
    chk_bit(irq_main, 1'b1, "irq_before_reset");
    bus_read(3'd3, 32'h08, "cap_before_reset");
    chipselect = 1'b1; read_n = 1'b0; address = 3'd3;
    sb_q.push_back('{exp: 32'h0, name: "inflight_read_reset"});
    #2 reset_n = 1'b0;
    #1;
    e = sb_q.pop_front();
    total++;
    if (rd_main !== e.exp) begin
      bad++;
      $display("FAIL %s: readdata=%h expected=%h", e.name, rd_main, e.exp);
    end
    chk_bit(irq_main, 1'b0, "irq_async_clear");
    chk_bit(irq_fall, 1'b0, "irq_fall_async_clear");
    chipselect = 1'b0; read_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(3'd3, 32'hAD, "cap_high_at_release");
    total++;
    if (rd_fall !== 32'h0) begin
      bad++;
      $display("FAIL no_spurious_fall: readdata=%h expected=%h", rd_fall, 32'h0);
    end
    total++;
    if (rd_any !== 32'h0) begin
      bad++;
      $display("FAIL no_spurious_any: readdata=%h expected=%h", rd_any, 32'h0);
    end
    chk_bit(irq_main, 1'b0, "irq_mask_reset");
  endtask

  initial begin
    test_reset();
    test_sync_capture();
    test_mask_clear();
    test_set_wins();
    test_edge_types();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
